srt_divider: RTL and testbench

SRT_DIVIDER -- requirements
Module: srt_divider

---
 rtl/srt_pkg.sv | 23 ++
 rtl/srt_lzc.sv | 29 ++
 rtl/srt_divider.sv | 179 +++++++++++++++++
 tb/tb_srt_divider.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srt_pkg.sv
// Shared types and constants for the radix-2 SRT divider.
// Holds the FSM state encoding, the quotient-digit encoding and the digit-select codes.
package srt_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StNorm = 3'd1,
        StIter = 3'd2,
        StFix  = 3'd3,
        StDone = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        DigitZero = 2'b00,
        DigitPos  = 2'b01,
        DigitNeg  = 2'b11
    } digit_e;

    // Top three bits of the shifted partial remainder that retire a zero digit.
    localparam logic [2:0] SelZeroPos = 3'b000;
    localparam logic [2:0] SelZeroNeg = 3'b111;

endpackage

// File: rtl/srt_lzc.sv
// Combinational leading-zero counter; o_count is WIDTH when the input is all zeros.
module srt_lzc #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic w_found;

    always_comb begin
        o_count = '0;
        w_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!w_found) begin
                if (i_data[i]) begin
                    w_found = 1'b1;
                end else begin
                    o_count = o_count + CNT_W'(1);
                end
            end
        end
    end

    assign o_zero = ~w_found;

endmodule

// File: rtl/srt_divider.sv
// Unsigned radix-2 SRT divider: normalise, WIDTH redundant-digit iterations, then a
// single carry-propagate fix-up that converts the digits and corrects a negative remainder.
module srt_divider
    import srt_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] DVD,
    input  logic [WIDTH-1:0] DSR,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DIV0
);

    localparam int unsigned PW = WIDTH + 2;

    state_e r_state;
    state_e w_state_next;

    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_qs;
    logic [WIDTH-1:0] r_qp;
    logic [WIDTH-1:0] r_qn;
    logic [PW-1:0]    r_pr;
    logic [CNT_W-1:0] r_z;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_div0;

    logic [CNT_W-1:0]   w_lzc_count;
    logic               w_dsr_zero;
    logic               w_accept;
    logic               w_iter_last;
    logic [2*WIDTH-1:0] w_norm;
    logic [WIDTH-1:0]   w_d_norm;
    logic [PW-1:0]      w_pr_sh;
    logic [PW-1:0]      w_pr_iter;
    logic [2:0]         w_top;
    digit_e             w_digit;
    logic [WIDTH-1:0]   w_q_raw;
    logic [WIDTH-1:0]   w_q_fix;
    logic [PW-1:0]      w_pr_fix;

    srt_lzc #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_lzc (
        .i_data  (r_dsr),
        .o_count (w_lzc_count),
        .o_zero  (w_dsr_zero)
    );

    assign w_accept    = START && (r_state == StIdle || r_state == StDone);
    assign w_iter_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        BUSY         = 1'b0;
        DONE         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (START) w_state_next = StNorm;
            end
            StNorm: begin
                BUSY         = 1'b1;
                w_state_next = w_dsr_zero ? StDone : StIter;
            end
            StIter: begin
                BUSY = 1'b1;
                if (w_iter_last) w_state_next = StFix;
            end
            StFix: begin
                BUSY         = 1'b1;
                w_state_next = StDone;
            end
            StDone: begin
                DONE         = 1'b1;
                w_state_next = START ? StNorm : StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Shifting {0, DVD} by z keeps dividend and divisor scaled by the same power of two.
    assign w_norm   = {{WIDTH{1'b0}}, r_dvd} << w_lzc_count;
    assign w_d_norm = r_dsr << w_lzc_count;

    always_comb begin
        w_pr_sh   = {r_pr[PW-2:0], r_qs[WIDTH-1]};
        w_top     = w_pr_sh[PW-1:PW-3];
        w_pr_iter = w_pr_sh;
        if (w_top == SelZeroPos || w_top == SelZeroNeg) begin
            w_digit = DigitZero;
        end else if (!w_top[2]) begin
            w_digit = DigitPos;
        end else begin
            w_digit = DigitNeg;
        end
        unique case (w_digit)
            DigitPos: w_pr_iter = w_pr_sh - {2'b00, r_d};
            DigitNeg: w_pr_iter = w_pr_sh + {2'b00, r_d};
            default:  w_pr_iter = w_pr_sh;
        endcase
    end

    assign w_q_raw  = r_qp - r_qn;
    assign w_q_fix  = r_pr[PW-1] ? w_q_raw - WIDTH'(1) : w_q_raw;
    assign w_pr_fix = r_pr[PW-1] ? r_pr + {2'b00, r_d} : r_pr;

    always_ff @(posedge CLK) begin
        unique case (r_state)
            StIdle, StDone: begin
                if (START) begin
                    r_dvd <= DVD;
                    r_dsr <= DSR;
                end
            end
            StNorm: begin
                r_z   <= w_lzc_count;
                r_d   <= w_d_norm;
                r_pr  <= {2'b00, w_norm[2*WIDTH-1:WIDTH]};
                r_qs  <= w_norm[WIDTH-1:0];
                r_qp  <= '0;
                r_qn  <= '0;
                r_cnt <= '0;
            end
            StIter: begin
                r_pr  <= w_pr_iter;
                r_qs  <= {r_qs[WIDTH-2:0], 1'b0};
                r_qp  <= {r_qp[WIDTH-2:0], w_digit == DigitPos};
                r_qn  <= {r_qn[WIDTH-2:0], w_digit == DigitNeg};
                r_cnt <= r_cnt + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_q    <= '0;
            r_r    <= '0;
            r_div0 <= 1'b0;
        end else begin
            if (w_accept) r_div0 <= 1'b0;
            if (r_state == StNorm && w_dsr_zero) begin
                r_div0 <= 1'b1;
                r_q    <= '1;
                r_r    <= r_dvd;
            end
            if (r_state == StFix) begin
                r_q <= w_q_fix;
                // Remainder is a multiple of 2^z, so the shift is exact.
                r_r <= WIDTH'(w_pr_fix >> r_z);
            end
        end
    end

    assign Q    = r_q;
    assign R    = r_r;
    assign DIV0 = r_div0;

endmodule

// File: tb/tb_srt_divider.sv
// Scoreboard bench: a 64-bit divider for directed and random cases and an 8-bit divider
// swept with random and structured operands, both checked against plain '/' and '%'.
module tb_srt_divider;

    localparam int unsigned WA = 64;
    localparam int unsigned WB = 8;

    typedef struct {
        logic [63:0] dvd;
        logic [63:0] dsr;
        logic [63:0] q;
        logic [63:0] r;
        logic        div0;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_a = 1'b0, start_a = 1'b0, busy_a, done_a, div0_a;
    logic [63:0] dvd_a = '0, dsr_a = '0, q_a, r_a;
    logic        rst_b = 1'b0, start_b = 1'b0, busy_b, done_b, div0_b;
    logic [7:0]  dvd_b = '0, dsr_b = '0, q_b, r_b;

    srt_divider #(.WIDTH(WA)) u_dut_a (
        .CLK (clk), .RST_N (rst_a), .START (start_a), .DVD (dvd_a), .DSR (dsr_a),
        .BUSY (busy_a), .DONE (done_a), .Q (q_a), .R (r_a), .DIV0 (div0_a)
    );

    srt_divider #(.WIDTH(WB)) u_dut_b (
        .CLK (clk), .RST_N (rst_b), .START (start_b), .DVD (dvd_b), .DSR (dsr_b),
        .BUSY (busy_b), .DONE (done_b), .Q (q_b), .R (r_b), .DIV0 (div0_b)
    );

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t ea, eb;
    int   n_cmp = 0, n_bad = 0;
    int   done_cnt_a = 0;
    logic [63:0] hold_qa = '0, hold_ra = '0, hold_qb = '0, hold_rb = '0;
    logic        hold_da = 1'b0, hold_db = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer division; divide-by-zero gives all ones and the dividend.
    function automatic exp_t model(input logic [63:0] dvd, input logic [63:0] dsr,
                                   input int w, input int acc);
        exp_t        e;
        logic [63:0] mask;
        mask  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        e.dvd = dvd;
        e.dsr = dsr;
        e.acc = acc;
        if (dsr == 64'd0) begin
            e.q = mask; e.r = dvd; e.div0 = 1'b1; e.lat = 2;
        end else begin
            e.q = dvd / dsr; e.r = dvd % dsr; e.div0 = 1'b0; e.lat = w + 3;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Latency counts the accepting edge as cycle 1.
    always @(negedge clk) begin
        if (done_a) begin
            done_cnt_a++;
            if (sb_a.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL a_unexpected_done: DONE high with Q=0x%0h, required no pending result",
                         q_a);
            end else begin
                ea = sb_a.pop_front();
                check("a_q", q_a, ea.q);
                check("a_r", r_a, ea.r);
                check("a_div0", 64'(div0_a), 64'(ea.div0));
                check("a_latency", 64'(cyc - ea.acc + 1), 64'(ea.lat));
                hold_qa = ea.q; hold_ra = ea.r; hold_da = ea.div0;
            end
        end
        if (!rst_a) begin
            sb_a.delete();
            hold_qa = '0; hold_ra = '0; hold_da = 1'b0;
        end else if (!done_a) begin
            check("a_q_hold", q_a, hold_qa);
            check("a_r_hold", r_a, hold_ra);
            if (!busy_a) check("a_div0_hold", 64'(div0_a), 64'(hold_da));
        end
    end

    always @(negedge clk) begin
        if (done_b) begin
            if (sb_b.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_unexpected_done: DONE high with Q=0x%0h, required no pending result",
                         q_b);
            end else begin
                eb = sb_b.pop_front();
                check("b_q", 64'(q_b), eb.q);
                check("b_r", 64'(r_b), eb.r);
                check("b_div0", 64'(div0_b), 64'(eb.div0));
                check("b_latency", 64'(cyc - eb.acc + 1), 64'(eb.lat));
                if (eb.dsr != 64'd0) begin
                    check("b_identity", 64'(q_b) * eb.dsr + 64'(r_b), eb.dvd);
                    check("b_r_below_dsr", 64'(64'(r_b) < eb.dsr), 64'd1);
                end
                hold_qb = eb.q; hold_rb = eb.r; hold_db = eb.div0;
            end
        end
        if (!rst_b) begin
            sb_b.delete();
            hold_qb = '0; hold_rb = '0; hold_db = 1'b0;
        end else if (!done_b) begin
            check("b_q_hold", 64'(q_b), hold_qb);
            check("b_r_hold", 64'(r_b), hold_rb);
            if (!busy_b) check("b_div0_hold", 64'(div0_b), 64'(hold_db));
        end
    end

    task automatic wait_idle_a();
        int k = 0;
        while (busy_a && k < int'(WA) + 10) begin
            step();
            k++;
        end
        if (busy_a) begin
            n_cmp++; n_bad++;
            $display("FAIL a_idle_timeout: BUSY still 1 after %0d cycles, required 0", k);
        end
    endtask

    task automatic wait_idle_b();
        int k = 0;
        while (busy_b && k < int'(WB) + 10) begin
            step();
            k++;
        end
        if (busy_b) begin
            n_cmp++; n_bad++;
            $display("FAIL b_idle_timeout: BUSY still 1 after %0d cycles, required 0", k);
        end
    endtask

    task automatic issue_a(input logic [63:0] dvd, input logic [63:0] dsr, input bit hold);
        wait_idle_a();
        start_a = 1'b1; dvd_a = dvd; dsr_a = dsr;
        step();
        sb_a.push_back(model(dvd, dsr, WA, cyc));
        check("a_busy_after_start", 64'(busy_a), 64'd1);
        if (!hold) start_a = 1'b0;
    endtask

    task automatic issue_b(input logic [7:0] dvd, input logic [7:0] dsr);
        wait_idle_b();
        start_b = 1'b1; dvd_b = dvd; dsr_b = dsr;
        step();
        sb_b.push_back(model(64'(dvd), 64'(dsr), WB, cyc));
        start_b = 1'b0;
    endtask

    task automatic reset_a(input bit with_start);
        rst_a = 1'b0; start_a = with_start; dvd_a = 64'h55; dsr_a = 64'h3;
        step();
        check("a_rst_busy", 64'(busy_a), 64'd0);
        check("a_rst_done", 64'(done_a), 64'd0);
        check("a_rst_div0", 64'(div0_a), 64'd0);
        check("a_rst_q", q_a, 64'd0);
        check("a_rst_r", r_a, 64'd0);
        start_a = 1'b0;
        step();
        rst_a = 1'b1;
    endtask

    task automatic run_a();
        logic [63:0] x, y;
        int          d0;
        reset_a(1'b0);
        issue_a(64'd8, 64'd3, 1'b0);
        issue_a(64'h1234, 64'd0, 1'b0);
        issue_a('1, 64'd1, 1'b0);
        issue_a(64'd5, 64'd7, 1'b0);
        // START pulsed mid-run must be ignored.
        issue_a(64'd100, 64'd7, 1'b0);
        repeat (9) step();
        start_a = 1'b1; dvd_a = 64'd999; dsr_a = 64'd5;
        step();
        start_a = 1'b0;
        check("a_busy_ignored_start", 64'(busy_a), 64'd1);
        // START held high through DONE chains a second division.
        issue_a(64'd1000, 64'd9, 1'b1);
        issue_a(64'd77, 64'd4, 1'b0);
        // Reset during ITER aborts the run; START in the same cycle loses.
        issue_a(64'hDEAD_BEEF_0123_4567, 64'h1_2345, 1'b0);
        repeat (20) step();
        reset_a(1'b1);
        d0 = done_cnt_a;
        repeat (WA + 8) step();
        check("a_no_done_after_abort", 64'(done_cnt_a - d0), 64'd0);
        // DIV0 and an all-ones Q must both clear on reset.
        issue_a(64'd5, 64'd0, 1'b0);
        wait_idle_a();
        step();
        reset_a(1'b0);
        for (int i = 0; i < 120; i++) begin
            x = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            y = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            if ($urandom_range(0, 15) == 0) y = 64'd0;
            issue_a(x, y, 1'b0);
        end
        wait_idle_a();
    endtask

    task automatic run_b();
        logic [7:0] x, y;
        repeat (3) step();
        check("b_rst_busy", 64'(busy_b), 64'd0);
        check("b_rst_q", 64'(q_b), 64'd0);
        rst_b = 1'b1;
        for (int i = 0; i < 2600; i++) begin
            if (i < 256) begin
                x = 8'($urandom_range(0, 255)); y = 8'(i);
            end else if (i < 512) begin
                x = 8'(i - 256); y = 8'($urandom_range(0, 255));
            end else begin
                x = 8'($urandom()); y = 8'($urandom());
            end
            issue_b(x, y);
        end
        issue_b(8'hFF, 8'h01);
        issue_b(8'hFF, 8'hFF);
        issue_b(8'h00, 8'h00);
        wait_idle_b();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1);
    end

    initial begin
        int k;
        fork
            run_a();
            run_b();
        join
        k = 0;
        while ((sb_a.size() != 0 || sb_b.size() != 0) && k < 200) begin
            step();
            k++;
        end
        while (sb_a.size() != 0) begin
            ea = sb_a.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL a_missing_done: got no DONE, required Q=0x%0h for dvd=0x%0h dsr=0x%0h",
                     ea.q, ea.dvd, ea.dsr);
        end
        while (sb_b.size() != 0) begin
            eb = sb_b.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL b_missing_done: got no DONE, required Q=0x%0h for dvd=0x%0h dsr=0x%0h",
                     eb.q, eb.dvd, eb.dsr);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
